// File: rtl/palette_out.sv
// palette_out: final pixel stage. Maps an 8-bit colour index {palette, pen}
// through a CPU-writable 256x16 palette RAM to 24-bit RGB. Pen 0 selects the
// backdrop colour, and a global 4-bit brightness scale is applied. Blanking
// forces black, and blank/sync are delayed so they stay aligned with the RGB.
//
// Ports
//   clk, reset_n            system clock, asynchronous active-low reset
//   ce_pixel                pixel enable (at most every 2nd clk)
//   wr[1:0]                 CPU byte write enables {hi, lo}
//   cs_ram / cs_reg         CPU select: palette RAM / control registers
//   address[7:0], din[15:0] CPU word address and write data
//   dout[15:0]              CPU read data, registered (1 clk after address)
//   color_in[7:0]           colour index from the tilemap
//   h/vblank_in, h/vsync_in timing inputs, aligned with color_in
//   red/green/blue[7:0]     pixel output
//   hblank/vblank/hsync/vsync  timing outputs, delayed to match the RGB
module palette_out (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce_pixel,
    input  logic [1:0]  wr,
    input  logic        cs_ram,
    input  logic        cs_reg,
    input  logic [7:0]  address,
    input  logic [15:0] din,
    output logic [15:0] dout,
    input  logic [7:0]  color_in,
    input  logic        hblank_in,
    input  logic        vblank_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        hblank,
    output logic        vblank,
    output logic        hsync,
    output logic        vsync
);

    localparam int unsigned IDX_W  = 8;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned COL_W  = 15;
    localparam int unsigned COMP_W = 5;
    localparam int unsigned CH_W   = 8;
    localparam int unsigned BRT_W  = 4;
    localparam int unsigned PROD_W = 12;
    localparam int unsigned DEPTH  = 256;

    // Palette RAM: one CPU write port, one pixel read port, one CPU read port.
    logic [WORD_W-1:0] mem [DEPTH];
    logic [COL_W-1:0]  pix_word_q;

    // Control registers
    logic [COL_W-1:0]  backdrop_q;
    logic [BRT_W-1:0]  bright_q;
    logic [WORD_W-1:0] reg_rd_c;
    logic [WORD_W-1:0] dout_q;
    logic [WORD_W-1:0] dout_d;

    // S1 pipeline registers
    logic s1_pen0_q;
    logic s1_hblank_q;
    logic s1_vblank_q;
    logic s1_hsync_q;
    logic s1_vsync_q;

    // S2 / output registers
    logic [COL_W-1:0] src_word_c;
    logic [CH_W-1:0]  red_q,   red_d;
    logic [CH_W-1:0]  green_q, green_d;
    logic [CH_W-1:0]  blue_q,  blue_d;
    logic             hblank_q;
    logic             vblank_q;
    logic             hsync_q;
    logic             vsync_q;

    // Expand 5-bit component to 8 bits and scale by (bright+1)/16.
    // 255*16 fits in 12 bits, so the top bit of the 13-bit product is never set.
    function automatic logic [CH_W-1:0] scale(input logic [COMP_W-1:0] c,
                                              input logic [BRT_W-1:0]  b);
        logic [CH_W-1:0]   e;
        logic [PROD_W-1:0] p;
        e = {c, c[COMP_W-1:COMP_W-3]};
        p = PROD_W'(e) * (PROD_W'(b) + PROD_W'(1));
        return p[PROD_W-1:4];
    endfunction

    // Palette RAM: read-before-write, so a colliding pixel read sees the old word.
    always_ff @(posedge clk) begin
        if (cs_ram && wr[0]) begin
            mem[address][7:0] <= din[7:0];
        end
        if (cs_ram && wr[1]) begin
            mem[address][15:8] <= din[15:8];
        end
        if (ce_pixel) begin
            pix_word_q <= mem[color_in][COL_W-1:0];
        end
    end

    // BACKDROP / BRIGHT registers with byte-lane writes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            backdrop_q <= '0;
            bright_q   <= BRT_W'(15);
        end else if (cs_reg) begin
            if (!address[0]) begin
                if (wr[0]) begin
                    backdrop_q[7:0] <= din[7:0];
                end
                if (wr[1]) begin
                    backdrop_q[14:8] <= din[14:8];
                end
            end else if (wr[0]) begin
                bright_q <= din[BRT_W-1:0];
            end
        end
    end

    // CPU readback mux; unused register bits read as 0.
    always_comb begin
        reg_rd_c = '0;
        dout_d   = '0;
        if (address[0]) begin
            reg_rd_c = WORD_W'(bright_q);
        end else begin
            reg_rd_c = WORD_W'(backdrop_q);
        end
        if (cs_reg) begin
            dout_d = reg_rd_c;
        end else begin
            dout_d = mem[address];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    // S2 colour computation.
    always_comb begin
        src_word_c = pix_word_q;
        red_d      = '0;
        green_d    = '0;
        blue_d     = '0;
        if (s1_pen0_q) begin
            src_word_c = backdrop_q;
        end
        if (!(s1_hblank_q || s1_vblank_q)) begin
            red_d   = scale(src_word_c[14:10], bright_q);
            green_d = scale(src_word_c[9:5],   bright_q);
            blue_d  = scale(src_word_c[4:0],   bright_q);
        end
    end

    // Two-stage pixel pipeline, advancing on ce_pixel.
    // S1 blanks reset as set so the first post-reset tick outputs black.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_pen0_q   <= 1'b0;
            s1_hblank_q <= 1'b1;
            s1_vblank_q <= 1'b1;
            s1_hsync_q  <= 1'b0;
            s1_vsync_q  <= 1'b0;
            red_q       <= '0;
            green_q     <= '0;
            blue_q      <= '0;
            hblank_q    <= 1'b1;
            vblank_q    <= 1'b1;
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
        end else if (ce_pixel) begin
            s1_pen0_q   <= (color_in[3:0] == 4'd0);
            s1_hblank_q <= hblank_in;
            s1_vblank_q <= vblank_in;
            s1_hsync_q  <= hsync_in;
            s1_vsync_q  <= vsync_in;
            red_q       <= red_d;
            green_q     <= green_d;
            blue_q      <= blue_d;
            hblank_q    <= s1_hblank_q;
            vblank_q    <= s1_vblank_q;
            hsync_q     <= s1_hsync_q;
            vsync_q     <= s1_vsync_q;
        end
    end

    assign dout   = dout_q;
    assign red    = red_q;
    assign green  = green_q;
    assign blue   = blue_q;
    assign hblank = hblank_q;
    assign vblank = vblank_q;
    assign hsync  = hsync_q;
    assign vsync  = vsync_q;

endmodule
